// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI-slave front end: FSM states, read sub-phases,
// default widths and command opcodes.
package spi_pkg;

    localparam int DEF_FRAME_W = 10;
    localparam int DEF_DATA_W  = 8;

    // Opcode lives in frame bits [9:8]
    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CHK_CMD,
        WRITE,
        READ_ADD,
        READ_DATA
    } state_t;

    typedef enum logic [1:0] {
        PH_RX,
        PH_WAIT_TX,
        PH_SHIFT_TX,
        PH_DONE
    } rd_phase_t;

endpackage

// File: rtl/spi_tx_serializer.sv
// MSB-first parallel-to-serial shifter for the read reply. load_i captures data_i and drives
// its MSB on the same edge; the remaining bits follow one per edge, then the line returns to 0.
module spi_tx_serializer
    import spi_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              serial_o,
    output logic              busy_o,
    output logic              last_o
);

    localparam int CNT_W = $clog2(DATA_W);

    logic [DATA_W-1:0] sr_q,   sr_d;
    logic [CNT_W-1:0]  left_q, left_d;
    logic              bit_q,  bit_d;
    logic              busy_q, busy_d;

    always_comb begin
        sr_d   = sr_q;
        left_d = left_q;
        bit_d  = bit_q;
        busy_d = busy_q;
        if (clear_i) begin
            sr_d   = '0;
            left_d = '0;
            bit_d  = 1'b0;
            busy_d = 1'b0;
        end else if (load_i) begin
            sr_d   = {data_i[DATA_W-2:0], 1'b0};
            left_d = CNT_W'(DATA_W - 1);
            bit_d  = data_i[DATA_W-1];
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (left_q != '0) begin
                bit_d  = sr_q[DATA_W-1];
                sr_d   = {sr_q[DATA_W-2:0], 1'b0};
                left_d = left_q - CNT_W'(1);
            end else begin
                // All bits have been on the line for one edge each; drop back to 0
                bit_d  = 1'b0;
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q   <= '0;
            left_q <= '0;
            bit_q  <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            sr_q   <= sr_d;
            left_q <= left_d;
            bit_q  <= bit_d;
            busy_q <= busy_d;
        end
    end

    assign serial_o = bit_q;
    assign busy_o   = busy_q;
    assign last_o   = busy_q && (left_q == '0);

endmodule

// File: rtl/spi_slave_if.sv
// SPI slave front end: assembles 10-bit MOSI command frames for the RAM, tracks whether a read
// address has been sent, and serialises the RAM's read reply onto MISO.
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               SS_n,
    input  logic               MOSI,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_valid,
    output logic               MISO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid,
    output state_t             state_o,
    output rd_phase_t          phase_o,
    output logic               rd_addr_seen_o
);

    // rx_valid is a single-cycle strobe with no back-pressure: rx_data is stable while it is high
    // and holds until the next strobe. tx_valid is a single-cycle strobe accepted only while a
    // read-data frame is waiting for its reply; strobes at any other time are dropped.

    localparam int                CNT_W    = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(FRAME_W - 2);

    state_t             state_q,      state_d;
    rd_phase_t          phase_q,      phase_d;
    logic [CNT_W-1:0]   cnt_q,        cnt_d;
    logic [FRAME_W-1:0] frame_q,      frame_d;
    logic               frame_done_q, frame_done_d;
    logic               rd_seen_q,    rd_seen_d;
    logic [FRAME_W-1:0] rx_data_q,    rx_data_d;
    logic               rx_valid_q,   rx_valid_d;

    logic ser_load;
    logic ser_clear;
    logic ser_busy;
    logic ser_last;
    logic rx_active;

    assign rx_active = ((state_q == WRITE || state_q == READ_ADD) && !frame_done_q) ||
                       (state_q == READ_DATA && phase_q == PH_RX);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        cnt_d        = cnt_q;
        frame_d      = frame_q;
        frame_done_d = frame_done_q;
        rd_seen_d    = rd_seen_q;
        rx_data_d    = rx_data_q;
        rx_valid_d   = 1'b0;
        ser_load     = 1'b0;
        ser_clear    = 1'b0;

        if (state_q != IDLE && SS_n) begin
            // Abort: any partial frame is dropped and the read-address flag is left alone
            state_d      = IDLE;
            phase_d      = PH_RX;
            cnt_d        = '0;
            frame_done_d = 1'b0;
            ser_clear    = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (!SS_n) begin
                        state_d      = CHK_CMD;
                        phase_d      = PH_RX;
                        cnt_d        = '0;
                        frame_done_d = 1'b0;
                    end
                end
                CHK_CMD: begin
                    frame_d = {{(FRAME_W-1){1'b0}}, MOSI};
                    cnt_d   = '0;
                    if (!MOSI) begin
                        state_d = WRITE;
                    end else if (!rd_seen_q) begin
                        state_d = READ_ADD;
                    end else begin
                        state_d = READ_DATA;
                    end
                end
                WRITE, READ_ADD: ;
                READ_DATA: begin
                    unique case (phase_q)
                        PH_WAIT_TX: begin
                            if (tx_valid) begin
                                ser_load = 1'b1;
                                phase_d  = PH_SHIFT_TX;
                            end
                        end
                        PH_SHIFT_TX: begin
                            if (ser_last || !ser_busy) begin
                                phase_d = PH_DONE;
                            end
                        end
                        default: ;
                    endcase
                end
                default: state_d = IDLE;
            endcase

            if (rx_active) begin
                frame_d = {frame_q[FRAME_W-2:0], MOSI};
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    rx_data_d  = {frame_q[FRAME_W-2:0], MOSI};
                    rx_valid_d = 1'b1;
                    cnt_d      = '0;
                    if (state_q == READ_DATA) begin
                        phase_d   = PH_WAIT_TX;
                        rd_seen_d = 1'b0;
                    end else begin
                        frame_done_d = 1'b1;
                        if (state_q == READ_ADD) begin
                            rd_seen_d = 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            phase_q      <= PH_RX;
            cnt_q        <= '0;
            frame_q      <= '0;
            frame_done_q <= 1'b0;
            rd_seen_q    <= 1'b0;
            rx_data_q    <= '0;
            rx_valid_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            cnt_q        <= cnt_d;
            frame_q      <= frame_d;
            frame_done_q <= frame_done_d;
            rd_seen_q    <= rd_seen_d;
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
        end
    end

    spi_tx_serializer #(
        .DATA_W (DATA_W)
    ) u_tx_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear_i  (ser_clear),
        .load_i   (ser_load),
        .data_i   (tx_data),
        .serial_o (MISO),
        .busy_o   (ser_busy),
        .last_o   (ser_last)
    );

    assign rx_data        = rx_data_q;
    assign rx_valid       = rx_valid_q;
    assign state_o        = state_q;
    assign phase_o        = phase_q;
    assign rd_addr_seen_o = rd_seen_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Bench for spi_slave_if: frame scenarios with a queue of expected rx frames and MISO bits.
module tb_spi_slave_if;
    import spi_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       SS_n;
    logic       MOSI;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       MISO;
    logic [9:0] rx_data;
    logic       rx_valid;
    state_t     state_o;
    rd_phase_t  phase_o;
    logic       seen_o;

    int   total = 0;
    int   bad   = 0;
    int   rxv_cnt = 0;
    logic miso_any;
    logic model_seen;

    logic [9:0] exp_q[$];
    logic [9:0] got_q[$];
    logic       miso_exp_q[$];

    spi_slave_if dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .SS_n           (SS_n),
        .MOSI           (MOSI),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .MISO           (MISO),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .state_o        (state_o),
        .phase_o        (phase_o),
        .rd_addr_seen_o (seen_o)
    );

    // clock / monitor
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1) begin
            got_q.push_back(rx_data);
            rxv_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic begin_frame();
        SS_n = 1'b0;
        MOSI = 1'b0;
        step();
    endtask

    task automatic shift_bits(input logic [9:0] f, input int hi, input int lo);
        for (int i = hi; i >= lo; i--) begin
            MOSI = f[i];
            step();
            miso_any = miso_any | MISO;
        end
    endtask

    task automatic end_frame();
        SS_n = 1'b1;
        MOSI = 1'b0;
        step();
    endtask

    // scenarios
    task automatic test_reset();
        rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        model_seen = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rst_miso got=%b exp=0", MISO); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); end
        total++; if (rx_data !== 10'h000) begin bad++; $display("FAIL rst_rx_data got=%h exp=000", rx_data); end
        total++; if (state_o !== IDLE) begin bad++; $display("FAIL rst_state got=%0d exp=%0d", state_o, IDLE); end
        total++; if (seen_o !== 1'b0) begin bad++; $display("FAIL rst_flag got=%b exp=0", seen_o); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_write_addr();
        logic [9:0] f, g, e;
        f = 10'h005;
        exp_q.push_back(f);
        rxv_cnt = 0; miso_any = 1'b0;
        begin_frame();
        shift_bits(f, 9, 9);
        total++; if (state_o !== WRITE) begin bad++; $display("FAIL wa_state got=%0d exp=%0d", state_o, WRITE); end
        shift_bits(f, 8, 1);
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL wa_early_valid got=%b exp=0", rx_valid); end
        shift_bits(f, 0, 0);
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL wa_valid_e10 got=%b exp=1", rx_valid); end
        step();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL wa_valid_e11 got=%b exp=0", rx_valid); end
        for (int i = 0; i < 4; i++) begin step(); miso_any = miso_any | MISO; end
        total++; if (rxv_cnt !== 1) begin bad++; $display("FAIL wa_pulses got=%0d exp=1", rxv_cnt); end
        total++;
        if (got_q.size() == 0) begin bad++; $display("FAIL wa_frame got=none exp=%h", exp_q[0]); end
        else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) begin bad++; $display("FAIL wa_frame got=%h exp=%h", g, e); end
        end
        total++; if (miso_any !== 1'b0) begin bad++; $display("FAIL wa_miso got=%b exp=0", miso_any); end
        total++; if (rx_data !== 10'h005) begin bad++; $display("FAIL wa_hold got=%h exp=005", rx_data); end
        end_frame();
        total++; if (state_o !== IDLE) begin bad++; $display("FAIL wa_idle got=%0d exp=%0d", state_o, IDLE); end
    endtask

    task automatic test_write_data();
        logic [9:0] f, g, e;
        f = 10'h1AA;
        exp_q.push_back(f);
        rxv_cnt = 0; miso_any = 1'b0;
        begin_frame();
        shift_bits(f, 9, 0);
        repeat (3) step();
        total++; if (rxv_cnt !== 1) begin bad++; $display("FAIL wd_pulses got=%0d exp=1", rxv_cnt); end
        total++;
        if (got_q.size() == 0) begin bad++; $display("FAIL wd_frame got=none exp=%h", exp_q[0]); end
        else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) begin bad++; $display("FAIL wd_frame got=%h exp=%h", g, e); end
        end
        total++; if (seen_o !== model_seen) begin bad++; $display("FAIL wd_flag got=%b exp=%b", seen_o, model_seen); end
        total++; if (miso_any !== 1'b0) begin bad++; $display("FAIL wd_miso got=%b exp=0", miso_any); end
        end_frame();
    endtask

    task automatic test_read();
        logic [9:0] f, g, e;
        logic       b;
        f = 10'h205;
        exp_q.push_back(f);
        rxv_cnt = 0;
        begin_frame();
        shift_bits(f, 9, 9);
        total++; if (state_o !== READ_ADD) begin bad++; $display("FAIL rd_add_state got=%0d exp=%0d", state_o, READ_ADD); end
        shift_bits(f, 8, 0);
        model_seen = 1'b1;
        step();
        total++; if (seen_o !== model_seen) begin bad++; $display("FAIL rd_flag_set got=%b exp=%b", seen_o, model_seen); end
        end_frame();
        f = 10'h3A5;
        exp_q.push_back(f);
        begin_frame();
        shift_bits(f, 9, 9);
        total++; if (state_o !== READ_DATA) begin bad++; $display("FAIL rd_data_state got=%0d exp=%0d", state_o, READ_DATA); end
        shift_bits(f, 8, 0);
        model_seen = 1'b0;
        step();
        total++; if (phase_o !== PH_WAIT_TX) begin bad++; $display("FAIL rd_wait got=%0d exp=%0d", phase_o, PH_WAIT_TX); end
        total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rd_miso_wait got=%b exp=0", MISO); end
        tx_data = 8'hAA; tx_valid = 1'b1;
        for (int i = 7; i >= 0; i--) miso_exp_q.push_back(tx_data[i]);
        step();
        tx_valid = 1'b0; tx_data = 8'h00;
        for (int k = 0; k < 8; k++) begin
            b = miso_exp_q.pop_front();
            total++; if (MISO !== b) begin bad++; $display("FAIL rd_miso_bit%0d got=%b exp=%b", k, MISO, b); end
            step();
        end
        total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rd_miso_tail got=%b exp=0", MISO); end
        total++; if (phase_o !== PH_DONE) begin bad++; $display("FAIL rd_done got=%0d exp=%0d", phase_o, PH_DONE); end
        total++; if (seen_o !== model_seen) begin bad++; $display("FAIL rd_flag_clr got=%b exp=%b", seen_o, model_seen); end
        total++; if (rxv_cnt !== 2) begin bad++; $display("FAIL rd_pulses got=%0d exp=2", rxv_cnt); end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (got_q.size() == 0) begin bad++; $display("FAIL rd_frame%0d got=none exp=%h", k, exp_q[0]); end
            else begin
                g = got_q.pop_front(); e = exp_q.pop_front();
                if (g !== e) begin bad++; $display("FAIL rd_frame%0d got=%h exp=%h", k, g, e); end
            end
        end
        end_frame();
    endtask

    task automatic test_abort();
        logic [9:0] f, g, e;
        rxv_cnt = 0;
        f = 10'h0C3;
        begin_frame();
        shift_bits(f, 9, 5);
        SS_n = 1'b1;
        step();
        total++; if (state_o !== IDLE) begin bad++; $display("FAIL ab5_state got=%0d exp=%0d", state_o, IDLE); end
        // abort exactly on the last bit edge
        f = 10'h2F0;
        begin_frame();
        shift_bits(f, 9, 1);
        SS_n = 1'b1; MOSI = f[0];
        step();
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ab10_valid got=%b exp=0", rx_valid); end
        total++; if (state_o !== IDLE) begin bad++; $display("FAIL ab10_state got=%0d exp=%0d", state_o, IDLE); end
        total++; if (seen_o !== model_seen) begin bad++; $display("FAIL ab_flag got=%b exp=%b", seen_o, model_seen); end
        total++; if (rxv_cnt !== 0) begin bad++; $display("FAIL ab_pulses got=%0d exp=0", rxv_cnt); end
        f = 10'h033;
        exp_q.push_back(f);
        begin_frame();
        shift_bits(f, 9, 0);
        step();
        total++;
        if (got_q.size() == 0) begin bad++; $display("FAIL ab_next_frame got=none exp=%h", exp_q[0]); end
        else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) begin bad++; $display("FAIL ab_next_frame got=%h exp=%h", g, e); end
        end
        end_frame();
    endtask

    task automatic test_reset_mid();
        logic [9:0] f, g, e;
        f = 10'h2C0;
        begin_frame(); shift_bits(f, 9, 0); end_frame();
        f = 10'h300;
        begin_frame(); shift_bits(f, 9, 0);
        step();
        tx_data = 8'hFF; tx_valid = 1'b1;
        step();
        tx_valid = 1'b0;
        repeat (3) step();
        total++; if (MISO !== 1'b1) begin bad++; $display("FAIL rm_miso_pre got=%b exp=1", MISO); end
        #1 rst_n = 1'b0;
        #1;
        model_seen = 1'b0;
        total++; if (MISO !== 1'b0) begin bad++; $display("FAIL rm_miso got=%b exp=0", MISO); end
        total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rm_valid got=%b exp=0", rx_valid); end
        total++; if (seen_o !== model_seen) begin bad++; $display("FAIL rm_flag got=%b exp=%b", seen_o, model_seen); end
        total++; if (state_o !== IDLE) begin bad++; $display("FAIL rm_state got=%0d exp=%0d", state_o, IDLE); end
        total++; if (rx_data !== 10'h000) begin bad++; $display("FAIL rm_rx_data got=%h exp=000", rx_data); end
        #1 rst_n = 1'b1; SS_n = 1'b1;
        got_q.delete(); exp_q.delete();
        step();
        f = 10'h3FF;
        exp_q.push_back(f);
        begin_frame();
        shift_bits(f, 9, 9);
        total++; if (state_o !== READ_ADD) begin bad++; $display("FAIL rm_route got=%0d exp=%0d", state_o, READ_ADD); end
        shift_bits(f, 8, 0);
        model_seen = 1'b1;
        step();
        total++;
        if (got_q.size() == 0) begin bad++; $display("FAIL rm_frame got=none exp=%h", exp_q[0]); end
        else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) begin bad++; $display("FAIL rm_frame got=%h exp=%h", g, e); end
        end
        total++; if (seen_o !== model_seen) begin bad++; $display("FAIL rm_flag_set got=%b exp=%b", seen_o, model_seen); end
        end_frame();
    endtask

    task automatic test_spurious_tx();
        logic [9:0] f, g, e;
        f = 10'h0F0;
        exp_q.push_back(f);
        miso_any = 1'b0;
        begin_frame();
        tx_data = 8'hFF;
        for (int i = 9; i >= 0; i--) begin
            tx_valid = (i % 3 == 0);
            MOSI = f[i];
            step();
            miso_any = miso_any | MISO;
        end
        tx_valid = 1'b1;
        repeat (3) begin step(); miso_any = miso_any | MISO; end
        tx_valid = 1'b0;
        total++; if (miso_any !== 1'b0) begin bad++; $display("FAIL sp_miso got=%b exp=0", miso_any); end
        total++;
        if (got_q.size() == 0) begin bad++; $display("FAIL sp_frame got=none exp=%h", exp_q[0]); end
        else begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            if (g !== e) begin bad++; $display("FAIL sp_frame got=%h exp=%h", g, e); end
        end
        total++; if (rx_data !== f) begin bad++; $display("FAIL sp_hold got=%h exp=%h", rx_data, f); end
        total++; if (seen_o !== model_seen) begin bad++; $display("FAIL sp_flag got=%b exp=%b", seen_o, model_seen); end
        end_frame();
    endtask

    task automatic test_back_to_back();
        logic [9:0] f, g, e;
        logic [7:0] d;
        logic       b;
        int         w;
        for (int n = 0; n < 4; n++) begin
            if (model_seen) begin
                // consume a pending read address with a read-data frame first
                f = 10'h300; exp_q.push_back(f);
                begin_frame(); shift_bits(f, 9, 0); model_seen = 1'b0; end_frame();
            end
            f = {2'b10, 8'($urandom_range(0, 255))};
            exp_q.push_back(f);
            begin_frame(); shift_bits(f, 9, 0); model_seen = 1'b1; end_frame();
            f = {2'b11, 8'($urandom_range(0, 255))};
            exp_q.push_back(f);
            begin_frame();
            shift_bits(f, 9, 9);
            total++; if (state_o !== READ_DATA) begin bad++; $display("FAIL bb%0d_state got=%0d exp=%0d", n, state_o, READ_DATA); end
            shift_bits(f, 8, 0);
            model_seen = 1'b0;
            w = $urandom_range(1, 4);
            repeat (w) step();
            total++; if (MISO !== 1'b0) begin bad++; $display("FAIL bb%0d_wait_miso got=%b exp=0", n, MISO); end
            d = 8'($urandom_range(0, 255));
            tx_data = d; tx_valid = 1'b1;
            for (int i = 7; i >= 0; i--) miso_exp_q.push_back(d[i]);
            step();
            tx_valid = 1'b0;
            for (int k = 0; k < 8; k++) begin
                b = miso_exp_q.pop_front();
                total++; if (MISO !== b) begin bad++; $display("FAIL bb%0d_bit%0d got=%b exp=%b", n, k, MISO, b); end
                step();
            end
            total++; if (MISO !== 1'b0) begin bad++; $display("FAIL bb%0d_tail got=%b exp=0", n, MISO); end
            total++; if (seen_o !== model_seen) begin bad++; $display("FAIL bb%0d_flag got=%b exp=%b", n, seen_o, model_seen); end
            end_frame();
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                total++;
                if (got_q.size() == 0) begin bad++; $display("FAIL bb%0d_frame got=none exp=%h", n, e); end
                else begin
                    g = got_q.pop_front();
                    if (g !== e) begin bad++; $display("FAIL bb%0d_frame got=%h exp=%h", n, g, e); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_addr();
        test_write_data();
        test_read();
        test_abort();
        test_reset_mid();
        test_spurious_tx();
        test_back_to_back();
        total++;
        if (got_q.size() != 0) begin bad++; $display("FAIL extra_frames got=%0d exp=0", got_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
